// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and types for the seven-segment capture
//               block: the sixteen hex glyphs (bit0=a .. bit6=g), the blank
//               pattern and the captured-word structure.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
    localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
    localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
    localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
    localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
    localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
    localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
    localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
    localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
    localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
    localparam logic [6:0] SEG_GLYPH_A = 7'h77;
    localparam logic [6:0] SEG_GLYPH_B = 7'h7C;
    localparam logic [6:0] SEG_GLYPH_C = 7'h39;
    localparam logic [6:0] SEG_GLYPH_D = 7'h5E;
    localparam logic [6:0] SEG_GLYPH_E = 7'h79;
    localparam logic [6:0] SEG_GLYPH_F = 7'h71;

    // All segments dark; never captured, whatever the dp bit says.
    localparam logic [6:0] SEG_BLANK   = 7'h00;

    typedef struct packed {
        logic [3:0] nibble;
        logic       dp;
        logic       err;
    } seg7_word_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_to_bin.sv
`default_nettype none
// ============================================================================
// Module      : seg7_to_bin
// Description : Combinational glyph lookup. Maps a 7-bit segment pattern to
//               its hex digit; unknown patterns give nibble=0, err=1.
//   seg    : in  7  segment pattern, bit0=a .. bit6=g
//   nibble : out 4  decoded hex digit (0 when err)
//   err    : out 1  pattern is not one of the sixteen hex glyphs
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_to_bin
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       err
);

    always_comb begin
        nibble = 4'h0;
        err    = 1'b0;
        case (seg)
            SEG_GLYPH_0: nibble = 4'h0;
            SEG_GLYPH_1: nibble = 4'h1;
            SEG_GLYPH_2: nibble = 4'h2;
            SEG_GLYPH_3: nibble = 4'h3;
            SEG_GLYPH_4: nibble = 4'h4;
            SEG_GLYPH_5: nibble = 4'h5;
            SEG_GLYPH_6: nibble = 4'h6;
            SEG_GLYPH_7: nibble = 4'h7;
            SEG_GLYPH_8: nibble = 4'h8;
            SEG_GLYPH_9: nibble = 4'h9;
            SEG_GLYPH_A: nibble = 4'hA;
            SEG_GLYPH_B: nibble = 4'hB;
            SEG_GLYPH_C: nibble = 4'hC;
            SEG_GLYPH_D: nibble = 4'hD;
            SEG_GLYPH_E: nibble = 4'hE;
            SEG_GLYPH_F: nibble = 4'hF;
            default:     err    = 1'b1;
        endcase
    end

endmodule : seg7_to_bin
`default_nettype wire

// File: rtl/seg7_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg7_capture
// Description : Synchronizes an asynchronous seven-segment bus, waits for a
//               pattern to stay stable, decodes it once per stable episode
//               and hands the result to a consumer through a single-entry
//               valid/ready buffer.
//   clk           : in  1  clock, rising edge
//   rst           : in  1  asynchronous active-high reset
//   seg_in        : in  8  segment bus, bit0=a .. bit6=g, bit7=dp (async)
//   out_ready     : in  1  consumer accepts the current word
//   out_valid     : out 1  buffered word valid
//   out_nibble    : out 4  decoded hex digit
//   out_dp        : out 1  captured dp bit
//   out_err       : out 1  captured pattern was not a hex glyph
//   overflow      : out 1  sticky: a capture was dropped (buffer full)
//   capture_count : out 8  captures loaded into the buffer, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_nibble,
    output logic       out_dp,
    output logic       out_err,
    output logic       overflow,
    output logic [7:0] capture_count
);

    localparam logic [7:0] c_cnt_max = 8'(STABLE_CYCLES - 1);

    logic [7:0] r_sync1;
    logic [7:0] r_sample;
    logic [7:0] r_prev;
    logic [7:0] r_cnt;
    logic       r_done;
    seg7_word_t r_word;
    logic       r_valid;
    logic       r_overflow;
    logic [7:0] r_count;

    logic       w_same;
    logic       w_capture;
    logic       w_load;
    logic [3:0] w_nibble;
    logic       w_err;

    // Two-flop synchronizer; everything downstream sees r_sample only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 8'h00;
            r_sample <= 8'h00;
        end else begin
            r_sync1  <= seg_in;
            r_sample <= r_sync1;
        end
    end

    assign w_same = (r_sample == r_prev);

    // r_done remembers that the counter already sat at its ceiling last
    // cycle, so the capture pulse fires only on the first arrival there.
    // Any change in the sample re-arms it.
    assign w_capture = w_same && (r_cnt == c_cnt_max) && !r_done &&
                       (r_sample[6:0] != SEG_BLANK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 8'h00;
            r_cnt  <= 8'h00;
            r_done <= 1'b0;
        end else begin
            r_prev <= r_sample;
            r_done <= w_same && (r_cnt == c_cnt_max);
            if (!w_same) begin
                r_cnt <= 8'h00;
            end else if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    seg7_to_bin u_seg7_to_bin (
        .seg    (r_sample[6:0]),
        .nibble (w_nibble),
        .err    (w_err)
    );

    // A capture may load when the buffer is empty or is being drained in
    // the same cycle; otherwise it is dropped and flagged.
    assign w_load = w_capture && (!r_valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_count    <= 8'h00;
        end else begin
            if (w_load) begin
                r_word.nibble <= w_nibble;
                r_word.dp     <= r_sample[7];
                r_word.err    <= w_err;
                r_valid       <= 1'b1;
                r_count       <= r_count + 8'd1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_capture && r_valid && !out_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_valid     = r_valid;
    assign out_nibble    = r_word.nibble;
    assign out_dp        = r_word.dp;
    assign out_err       = r_word.err;
    assign overflow      = r_overflow;
    assign capture_count = r_count;

endmodule : seg7_capture
`default_nettype wire

// File: tb/tb_seg7_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_capture
// Description : Self-checking bench for seg7_capture. A behavioural model
//               tracks how long each synchronized value has persisted and
//               predicts the buffered word; a compare process checks every
//               cycle, and directed scenarios pin literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_capture;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg_in = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [3:0] out_nibble;
    logic       out_dp;
    logic       out_err;
    logic       overflow;
    logic [7:0] capture_count;

    int tests = 0;
    int fails = 0;

    seg7_capture #(.STABLE_CYCLES(S)) dut (
        .clk           (clk),
        .rst           (rst),
        .seg_in        (seg_in),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_nibble    (out_nibble),
        .out_dp        (out_dp),
        .out_err       (out_err),
        .overflow      (overflow),
        .capture_count (capture_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                               7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                               7'h39, 7'h5E, 7'h79, 7'h71};

    logic [7:0] m_pipe1, m_pipe2;   // value seen one / two edges ago
    logic [7:0] m_last;
    int         m_run;              // edges for which the sample has persisted
    logic       m_valid, m_dp, m_err, m_ovf;
    logic [3:0] m_nib;
    int         m_cnt;

    always @(posedge clk) begin
        logic [7:0] s;
        logic       cap, found;
        if (rst) begin
            m_pipe1 = 8'h00; m_pipe2 = 8'h00; m_last = 8'h00; m_run = 0;
            m_valid = 1'b0; m_nib = 4'h0; m_dp = 1'b0; m_err = 1'b0;
            m_ovf = 1'b0; m_cnt = 0;
        end else begin
            s = m_pipe2;
            if (s == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else m_run = 1;
            m_last = s;
            // S identical comparisons need S+1 consecutive samples.
            cap = (m_run == S + 1) && (s[6:0] != 7'h00);
            if (cap) begin
                if (!m_valid || out_ready) begin
                    found = 1'b0;
                    m_nib = 4'h0;
                    for (int i = 0; i < 16; i++)
                        if (glyph[i] == s[6:0]) begin found = 1'b1; m_nib = 4'(i); end
                    m_err   = !found;
                    m_dp    = s[7];
                    m_valid = 1'b1;
                    m_cnt   = (m_cnt + 1) % 256;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            m_pipe2 = m_pipe1;
            m_pipe1 = seg_in;
        end
    end

    always @(negedge clk) begin
        tests++;
        if (out_valid !== m_valid || out_nibble !== m_nib || out_dp !== m_dp ||
            out_err !== m_err || overflow !== m_ovf || capture_count !== 8'(m_cnt)) begin
            fails++;
            $display("FAIL cycle_cmp t=%0t got v=%b n=%h dp=%b e=%b ov=%b c=%0d expected v=%b n=%h dp=%b e=%b ov=%b c=%0d",
                     $time, out_valid, out_nibble, out_dp, out_err, overflow, capture_count,
                     m_valid, m_nib, m_dp, m_err, m_ovf, m_cnt[7:0]);
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        step(3);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_nibble", int'(out_nibble), 0);
        chk("rst_flags", int'({out_dp, out_err, overflow}), 0);
        chk("rst_count", int'(capture_count), 0);

        // Latency: valid rises exactly at edge S+3 after release.
        seg_in = 8'h5B; rst = 1'b0;
        step(S + 2);
        chk("lat_not_yet", int'(out_valid), 0);
        step(1);
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_nibble", int'(out_nibble), 2);
        chk("lat_dp_err", int'({out_dp, out_err}), 0);
        chk("lat_count", int'(capture_count), 1);
        step(5);
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_nibble", int'(out_nibble), 2);
        chk("hold_count", int'(capture_count), 1);

        out_ready = 1'b1; step(1); out_ready = 1'b0;
        chk("drain_valid", int'(out_valid), 0);

        // Toggle faster than the stability window: nothing captured.
        for (int i = 0; i < 6; i++) begin
            seg_in = (i % 2 == 0) ? 8'h3F : 8'h06;
            step(2);
        end
        chk("toggle_count", int'(capture_count), 1);
        chk("toggle_valid", int'(out_valid), 0);
        step(10);
        chk("settle_count", int'(capture_count), 2);
        chk("settle_nibble", int'(out_nibble), 1);

        // Capture on the very cycle the consumer drains the old word.
        seg_in = 8'h3F;
        step(S + 2);
        chk("coin_pre_valid", int'(out_valid), 1);
        chk("coin_pre_nibble", int'(out_nibble), 1);
        out_ready = 1'b1; step(1); out_ready = 1'b0;
        chk("coin_valid", int'(out_valid), 1);
        chk("coin_nibble", int'(out_nibble), 0);
        chk("coin_count", int'(capture_count), 3);
        chk("coin_ovf", int'(overflow), 0);

        // Buffer full: blank makes nothing, F9 gets dropped.
        out_ready = 1'b1; step(1); out_ready = 1'b0;
        seg_in = 8'h77; step(10);
        chk("a_nibble", int'(out_nibble), 10);
        chk("a_count", int'(capture_count), 4);
        seg_in = 8'h00; step(10);
        chk("blank_count", int'(capture_count), 4);
        chk("blank_ovf", int'(overflow), 0);
        seg_in = 8'hF9; step(10);
        chk("drop_ovf", int'(overflow), 1);
        chk("drop_nibble", int'(out_nibble), 10);
        chk("drop_dp", int'(out_dp), 0);
        chk("drop_count", int'(capture_count), 4);

        // Unknown glyph.
        out_ready = 1'b1; step(1); out_ready = 1'b0;
        seg_in = 8'h49; step(10);
        chk("err_flag", int'(out_err), 1);
        chk("err_nibble", int'(out_nibble), 0);
        chk("err_count", int'(capture_count), 5);
        chk("ovf_sticky", int'(overflow), 1);

        // Reset mid-count with the buffer full, pattern held through release.
        seg_in = 8'h6D; step(3);
        rst = 1'b1; step(2);
        chk("mid_rst_outs", int'({out_valid, out_nibble, out_dp, out_err, overflow}), 0);
        chk("mid_rst_count", int'(capture_count), 0);
        rst = 1'b0;
        step(S + 2);
        chk("rel_not_yet", int'(out_valid), 0);
        step(1);
        chk("rel_valid", int'(out_valid), 1);
        chk("rel_nibble", int'(out_nibble), 5);
        chk("rel_count", int'(capture_count), 1);
        step(10);
        chk("rel_once", int'(capture_count), 1);

        // Randomized phase, checked cycle by cycle against the model.
        for (int k = 0; k < 500; k++) begin
            int sel, hold;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      seg_in = {1'($urandom_range(0, 1)), 7'h00};
            else if (sel == 1) seg_in = 8'($urandom);
            else               seg_in = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 15)]};
            hold = int'($urandom_range(1, 9));
            for (int c = 0; c < hold; c++) begin
                out_ready = ($urandom_range(0, 3) == 0);
                rst = ($urandom_range(0, 199) == 0);
                step(1);
            end
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_seg7_capture
`default_nettype wire
